// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps {A,B,C} through all 8 vectors, samples f after a settle window,
// and compares the captured truth table with EXPECTED.
// Ports: clk, rst (async, active-high), start (accepted in IDLE), f (unit output)
//        -> A/B/C (unit inputs, A = MSB), busy, done (1-cycle pulse), pass,
//        captured[7:0] (f per vector), mismatch[7:0] (captured ^ EXPECTED).
module truth_table_checker #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'b11101000,
  parameter int          CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] captured,
  output logic [7:0] mismatch
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam int S_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(S_EFF - 1);
  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d, abc_q, abc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]       captured_q, captured_d, mismatch_q, mismatch_d;
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    abc_d      = abc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    captured_d = captured_q;
    mismatch_d = mismatch_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = SETTLE;
        idx_d      = 3'd0;
        abc_d      = 3'd0;
        cnt_d      = '0;
        captured_d = 8'h00;
        mismatch_d = 8'h00;
        pass_d     = 1'b0;
        busy_d     = 1'b1;
      end
      SETTLE: begin
        state_d = (cnt_q == LAST) ? SAMPLE : SETTLE;
        cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
      end
      SAMPLE: begin
        captured_d[idx_q] = f;
        mismatch_d[idx_q] = f ^ EXPECTED[idx_q];
        // pass must include the bit sampled on this same edge
        if (idx_q == 3'd7) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (mismatch_d == 8'h00);
          abc_d   = 3'd0;
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 3'd1;
          abc_d   = idx_q + 3'd1;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      abc_q      <= 3'd0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      captured_q <= 8'h00;
      mismatch_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      abc_q      <= abc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      captured_q <= captured_d;
      mismatch_q <= mismatch_d;
    end
  end
  assign {A, B, C} = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign captured  = captured_q;
  assign mismatch  = mismatch_q;
endmodule
